// File: rtl/ntt_stage_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ntt_stage_sched : radix-2 NTT stage/issue scheduler with write-back replay  |
// | Optional INTT_EN macro adds the inv port and inverse stage ordering.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module ntt_stage_sched #(
  parameter int LOGN    = 8,
  parameter int BFU_LOG = 2,
  parameter int BFU_LAT = 7,
  localparam int IDX_W  = LOGN - 1 - BFU_LOG,
  localparam int STG_W  = $clog2(LOGN),
`ifdef INTT_EN
  localparam int TW_W   = STG_W + IDX_W + 1
`else
  localparam int TW_W   = STG_W + IDX_W
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef INTT_EN
  input  logic             inv,
`endif
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_idx,
  output logic [STG_W-1:0] stage,
  output logic [TW_W-1:0]  tw_addr,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output logic [STG_W-1:0] wr_stage
);

  localparam int ISSUE = 2 ** IDX_W;
  localparam int CNT_W = (BFU_LAT > 1) ? $clog2(BFU_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic             en;
    logic [IDX_W-1:0] idx;
    logic [STG_W-1:0] stg;
  } dly_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [STG_W-1:0] stage_q, stage_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inv_q, inv_d;
  logic             rd_en_q, rd_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [TW_W-1:0]  tw_addr_q, tw_addr_d;
  dly_t             dly_q [BFU_LAT];
  dly_t             dly_d [BFU_LAT];

  logic             inv_in;
  logic             last_idx;
  logic             last_stage;
  logic [STG_W-1:0] first_stage;

`ifdef INTT_EN
  assign inv_in = inv;
`else
  assign inv_in = 1'b0;
`endif

  assign last_idx    = (rd_idx_q == IDX_W'(ISSUE - 1));
  assign last_stage  = inv_q ? (stage_q == '0) : (stage_q == STG_W'(LOGN - 1));
  assign first_stage = inv_in ? STG_W'(LOGN - 1) : '0;

  always_comb begin
    state_d  = state_q;
    rd_idx_d = rd_idx_q;
    stage_d  = stage_q;
    cnt_d    = cnt_q;
    inv_d    = inv_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          rd_idx_d = '0;
          stage_d  = first_stage;
          inv_d    = inv_in;
        end
      end
      S_RUN: begin
        if (last_idx) begin
          state_d = S_DRAIN;
          cnt_d   = CNT_W'(BFU_LAT - 1);
        end else begin
          rd_idx_d = rd_idx_q + IDX_W'(1);
        end
      end
      S_DRAIN: begin
        // The drain length equals the BFU latency, so the next stage's first
        // read lands one cycle after this stage's last write-back.
        if (cnt_q == '0) begin
          if (last_stage) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_RUN;
            rd_idx_d = '0;
            stage_d  = inv_q ? (stage_q - STG_W'(1)) : (stage_q + STG_W'(1));
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        rd_idx_d = '0;
        stage_d  = '0;
        inv_d    = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    rd_en_d = (state_d == S_RUN);
    busy_d  = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d  = (state_d == S_DONE);
`ifdef INTT_EN
    tw_addr_d = {inv_d, stage_d, rd_idx_d};
`else
    tw_addr_d = {stage_d, rd_idx_d};
`endif

    dly_d[0] = {rd_en_q, rd_idx_q, stage_q};
    for (int i = 1; i < BFU_LAT; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rd_idx_q  <= '0;
      stage_q   <= '0;
      cnt_q     <= '0;
      inv_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tw_addr_q <= '0;
      for (int i = 0; i < BFU_LAT; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      rd_idx_q  <= rd_idx_d;
      stage_q   <= stage_d;
      cnt_q     <= cnt_d;
      inv_q     <= inv_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tw_addr_q <= tw_addr_d;
      for (int i = 0; i < BFU_LAT; i++) begin
        dly_q[i] <= dly_d[i];
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_en    = rd_en_q;
  assign rd_idx   = rd_idx_q;
  assign stage    = stage_q;
  assign tw_addr  = tw_addr_q;
  assign wr_en    = dly_q[BFU_LAT-1].en;
  assign wr_idx   = dly_q[BFU_LAT-1].idx;
  assign wr_stage = dly_q[BFU_LAT-1].stg;

endmodule
`default_nettype wire

// File: tb/tb_ntt_stage_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ntt_stage_sched : directed table-driven bench for ntt_stage_sched        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_ntt_stage_sched;

`ifdef INTT_EN
  localparam int TW_W = 9;
`else
  localparam int TW_W = 8;
`endif

  logic            clk   = 1'b0;
  logic            rst   = 1'b0;
  logic            start = 1'b0;
  logic            busy, done, rd_en, wr_en;
  logic [4:0]      rd_idx, wr_idx;
  logic [2:0]      stage, wr_stage;
  logic [TW_W-1:0] tw_addr;
`ifdef INTT_EN
  logic            inv = 1'b0;
`endif

  always #5 clk = ~clk;

  ntt_stage_sched dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
`ifdef INTT_EN
    .inv      (inv),
`endif
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_idx   (rd_idx),
    .stage    (stage),
    .tw_addr  (tw_addr),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_stage (wr_stage)
  );

  typedef struct {
    int              cyc;
    logic            start;
    logic            rd_en;
    logic [4:0]      rd_idx;
    logic [2:0]      stage;
    logic [TW_W-1:0] tw;
    logic            wr_en;
    logic [4:0]      wr_idx;
    logic [2:0]      wr_stage;
    logic            busy;
    logic            done;
  } vec_t;

  vec_t vt[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, c, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int c, input logic s, input logic re, input int ri, input int st,
                     input int tw, input logic we, input int wi, input int ws,
                     input logic b, input logic d);
    vec_t v;
    v.cyc = c; v.start = s; v.rd_en = re; v.rd_idx = 5'(ri); v.stage = 3'(st);
    v.tw = TW_W'(tw); v.wr_en = we; v.wr_idx = 5'(wi); v.wr_stage = 3'(ws);
    v.busy = b; v.done = d;
    vt.push_back(v);
  endtask

  // Runs one forward transform; the current cycle is cycle 0.
  task automatic run_table(input string tag);
    int vi, n_rd, n_wr, n_busy, n_done, done_at;
    vi = 0; n_rd = 0; n_wr = 0; n_busy = 0; n_done = 0; done_at = -1;
    for (int c = 0; c <= 330; c++) begin
      if (rd_en === 1'b1) n_rd++;
      if (wr_en === 1'b1) n_wr++;
      if (busy === 1'b1) n_busy++;
      if (done === 1'b1) begin n_done++; done_at = c; end
      start = 1'b0;
      if (vi < vt.size() && vt[vi].cyc == c) begin
        chk({tag, "rd_en"}, c, 32'(rd_en), 32'(vt[vi].rd_en));
        chk({tag, "wr_en"}, c, 32'(wr_en), 32'(vt[vi].wr_en));
        chk({tag, "busy"},  c, 32'(busy),  32'(vt[vi].busy));
        chk({tag, "done"},  c, 32'(done),  32'(vt[vi].done));
        if (vt[vi].rd_en) begin
          chk({tag, "rd_idx"},  c, 32'(rd_idx),  32'(vt[vi].rd_idx));
          chk({tag, "stage"},   c, 32'(stage),   32'(vt[vi].stage));
          chk({tag, "tw_addr"}, c, 32'(tw_addr), 32'(vt[vi].tw));
        end
        if (vt[vi].wr_en) begin
          chk({tag, "wr_idx"},   c, 32'(wr_idx),   32'(vt[vi].wr_idx));
          chk({tag, "wr_stage"}, c, 32'(wr_stage), 32'(vt[vi].wr_stage));
        end
        start = vt[vi].start;
        vi++;
      end
      tick();
    end
    start = 1'b0;
    chk({tag, "rd_count"},   330, 32'(n_rd),    32'd256);
    chk({tag, "wr_count"},   330, 32'(n_wr),    32'd256);
    chk({tag, "busy_count"}, 330, 32'(n_busy),  32'd312);
    chk({tag, "done_count"}, 330, 32'(n_done),  32'd1);
    chk({tag, "done_cycle"}, 330, 32'(done_at), 32'd313);
  endtask

  initial begin
    int n_act;
    int done_at;

    //     cyc  st rd idx stg tw   wr widx wstg busy done
    add(  0, 1, 0,  0, 0,   0, 0,  0, 0, 0, 0);
    add(  1, 0, 1,  0, 0,   0, 0,  0, 0, 1, 0);
    add(  7, 0, 1,  6, 0,   6, 0,  0, 0, 1, 0);
    add(  8, 0, 1,  7, 0,   7, 1,  0, 0, 1, 0);
    add( 32, 0, 1, 31, 0,  31, 1, 24, 0, 1, 0);
    add( 33, 0, 0,  0, 0,   0, 1, 25, 0, 1, 0);
    add( 39, 0, 0,  0, 0,   0, 1, 31, 0, 1, 0);
    add( 40, 0, 1,  0, 1,  32, 0,  0, 0, 1, 0);
    add( 47, 0, 1,  7, 1,  39, 1,  0, 1, 1, 0);
    add( 50, 1, 1, 10, 1,  42, 1,  3, 1, 1, 0);
    add( 51, 0, 1, 11, 1,  43, 1,  4, 1, 1, 0);
    add(274, 0, 1,  0, 7, 224, 0,  0, 0, 1, 0);
    add(305, 0, 1, 31, 7, 255, 1, 24, 7, 1, 0);
    add(312, 0, 0,  0, 0,   0, 1, 31, 7, 1, 0);
    add(313, 1, 0,  0, 0,   0, 0,  0, 0, 0, 1);
    add(314, 0, 0,  0, 0,   0, 0,  0, 0, 0, 0);
    add(315, 0, 0,  0, 0,   0, 0,  0, 0, 0, 0);

    // Reset held with start toggling: everything stays quiet.
    n_act = 0;
    for (int i = 0; i < 6; i++) begin
      start = ~start;
      tick();
      if ((rd_en | wr_en | busy | done) !== 1'b0 || rd_idx !== '0 || stage !== '0 ||
          tw_addr !== '0 || wr_idx !== '0 || wr_stage !== '0) n_act++;
    end
    chk("reset_hold_outputs", 6, 32'(n_act), 32'd0);
    start = 1'b0;
    rst   = 1'b1;
    n_act = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ((rd_en | wr_en | busy | done) !== 1'b0) n_act++;
    end
    chk("post_release_idle", 11, 32'(n_act), 32'd0);

    run_table("fwd_");

    // Async reset in the middle of stage 2.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 100; c++) tick();
    chk("pre_rst_rd_en", 100, 32'(rd_en), 32'd1);
    chk("pre_rst_wr_en", 100, 32'(wr_en), 32'd1);
    rst = 1'b0;
    #2;
    chk("rst_rd_en",    100, 32'(rd_en),    32'd0);
    chk("rst_wr_en",    100, 32'(wr_en),    32'd0);
    chk("rst_busy",     100, 32'(busy),     32'd0);
    chk("rst_rd_idx",   100, 32'(rd_idx),   32'd0);
    chk("rst_stage",    100, 32'(stage),    32'd0);
    chk("rst_tw_addr",  100, 32'(tw_addr),  32'd0);
    chk("rst_wr_idx",   100, 32'(wr_idx),   32'd0);
    chk("rst_wr_stage", 100, 32'(wr_stage), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    n_act = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if ((rd_en | wr_en | busy | done) !== 1'b0) n_act++;
    end
    chk("post_rst_quiet", 140, 32'(n_act), 32'd0);

    run_table("rerun_");

`ifdef INTT_EN
    // Inverse transform: inv is captured at start, stages run 7 down to 0.
    inv     = 1'b1;
    start   = 1'b1;
    done_at = -1;
    for (int c = 0; c <= 330; c++) begin
      if (done === 1'b1 && done_at < 0) done_at = c;
      if (c == 1) begin
        chk("inv_c1_stage",   c, 32'(stage),   32'd7);
        chk("inv_c1_tw_addr", c, 32'(tw_addr), 32'h1E0);
        inv = 1'b0;
      end
      if (c == 40) begin
        chk("inv_c40_stage",   c, 32'(stage),   32'd6);
        chk("inv_c40_tw_addr", c, 32'(tw_addr), 32'd448);
      end
      if (c == 274) begin
        chk("inv_c274_rd_en",   c, 32'(rd_en),   32'd1);
        chk("inv_c274_stage",   c, 32'(stage),   32'd0);
        chk("inv_c274_tw_addr", c, 32'(tw_addr), 32'd256);
      end
      if (c == 312) chk("inv_c312_wr_stage", c, 32'(wr_stage), 32'd0);
      tick();
      start = 1'b0;
    end
    chk("inv_done_cycle", 330, 32'(done_at), 32'd313);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
